// File: rtl/gci_std_display_vram_responder_if.sv
// Display VRAM read bus: requester-side session/read handshake plus the
// memory-controller read port. The responder uses the slave view.
interface gci_std_display_vram_responder_if #(
    parameter int P_MEM_ADDR_N = 19
);
    logic                    iIF_REQ;
    logic                    oIF_ACK;
    logic                    iIF_FINISH;
    logic                    iIF_ENA;
    logic                    oIF_BUSY;
    logic [P_MEM_ADDR_N-1:0] iIF_ADDR;
    logic                    oIF_VALID;
    logic [31:0]             oIF_DATA;
    logic                    oMEM_REQ;
    logic [P_MEM_ADDR_N-1:0] oMEM_ADDR;
    logic                    iMEM_BUSY;
    logic                    iMEM_VALID;
    logic [31:0]             iMEM_DATA;

    modport slave (
        input  iIF_REQ, iIF_FINISH, iIF_ENA, iIF_ADDR,
        input  iMEM_BUSY, iMEM_VALID, iMEM_DATA,
        output oIF_ACK, oIF_BUSY, oIF_VALID, oIF_DATA,
        output oMEM_REQ, oMEM_ADDR
    );

    modport master (
        output iIF_REQ, iIF_FINISH, iIF_ENA, iIF_ADDR,
        output iMEM_BUSY, iMEM_VALID, iMEM_DATA,
        input  oIF_ACK, oIF_BUSY, oIF_VALID, oIF_DATA,
        input  oMEM_REQ, oMEM_ADDR
    );
endinterface

// File: rtl/gci_std_display_vram_responder.sv
// Memory-side responder for the display VRAM read interface. Grants one
// read session at a time, forwards accepted read addresses to the memory
// port through a one-entry request register, and returns in-order memory
// data. After a synchronous flush, reads still in flight at the memory are
// counted down and swallowed before a new session may be granted.
module gci_std_display_vram_responder #(
    parameter int P_MEM_ADDR_N      = 19,
    parameter int P_MAX_OUTSTANDING = 4,
    parameter int P_OUTSTANDING_N   = 3
)(
    input  logic                           iGCI_CLOCK,
    input  logic                           inRESET,
    input  logic                           iRESET_SYNC,
    input  logic                           iARB_LOCK,
    gci_std_display_vram_responder_if.slave bus,
    output logic                           oERR
);
    localparam logic [P_OUTSTANDING_N-1:0] ONE     = P_OUTSTANDING_N'(1);
    localparam logic [P_OUTSTANDING_N-1:0] MAX_OUT = P_OUTSTANDING_N'(P_MAX_OUTSTANDING);

    typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_SESSION, ST_DRAIN} state_t;

    state_t                      state, state_nxt;
    logic [P_OUTSTANDING_N-1:0]  outstanding, outstanding_nxt;
    logic [P_OUTSTANDING_N-1:0]  discard, discard_dec, discard_load;
    logic [P_OUTSTANDING_N:0]    flush_avail, flush_drop;
    logic                        mem_req;
    logic [P_MEM_ADDR_N-1:0]     mem_addr;
    logic                        if_valid;
    logic [31:0]                 if_data;
    logic                        stalled, busy, accept, issue, fwd, unsol;

    // A request still waiting on the memory blocks new accepts so the
    // single request register is never overwritten while stalled.
    assign stalled = mem_req && bus.iMEM_BUSY;
    assign busy    = (state != ST_SESSION) || (outstanding >= MAX_OUT) || stalled;
    assign accept  = (state == ST_SESSION) && bus.iIF_ENA && !busy && !bus.iIF_FINISH;
    assign issue   = mem_req && !bus.iMEM_BUSY;
    assign fwd     = bus.iMEM_VALID && (discard == '0) && (outstanding != '0);
    assign unsol   = bus.iMEM_VALID && (discard == '0) && (outstanding == '0);

    assign bus.oIF_ACK   = (state == ST_ACK);
    assign bus.oIF_BUSY  = busy;
    assign bus.oIF_VALID = if_valid;
    assign bus.oIF_DATA  = if_data;
    assign bus.oMEM_REQ  = mem_req;
    assign bus.oMEM_ADDR = mem_addr;

    // Outstanding count update and flush bookkeeping. On a flush, every read
    // already handed to the memory (plus any earlier undrained discards) must
    // be swallowed later; the stalled request and a same-cycle return do not.
    always_comb begin
        outstanding_nxt = outstanding;
        if (accept && !fwd)
            outstanding_nxt = outstanding + ONE;
        else if (!accept && fwd)
            outstanding_nxt = outstanding - ONE;
        discard_dec = discard;
        if (bus.iMEM_VALID && (discard != '0))
            discard_dec = discard - ONE;
        flush_avail  = {1'b0, outstanding} + {1'b0, discard_dec};
        flush_drop   = (P_OUTSTANDING_N+1)'(stalled) + (P_OUTSTANDING_N+1)'(fwd);
        discard_load = '0;
        if (flush_avail > flush_drop)
            discard_load = P_OUTSTANDING_N'(flush_avail - flush_drop);
    end

    // Session state register.
    always_ff @(posedge iGCI_CLOCK or negedge inRESET) begin
        if (!inRESET) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Session next-state: grant, session, drain of in-flight reads.
    always_comb begin
        state_nxt = state;
        if (iRESET_SYNC) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (bus.iIF_REQ && !iARB_LOCK && (discard == '0)) state_nxt = ST_ACK;
                ST_ACK:     state_nxt = ST_SESSION;
                ST_SESSION: if (bus.iIF_FINISH)
                                state_nxt = (outstanding != '0) ? ST_DRAIN : ST_IDLE;
                ST_DRAIN:   if (outstanding_nxt == '0) state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outstanding and discard counters.
    always_ff @(posedge iGCI_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            outstanding <= '0;
            discard     <= '0;
        end else if (iRESET_SYNC) begin
            outstanding <= '0;
            discard     <= discard_load;
        end else begin
            outstanding <= outstanding_nxt;
            discard     <= discard_dec;
        end
    end

    // Memory request register: load on accept, hold while stalled, drop on issue.
    always_ff @(posedge iGCI_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (iRESET_SYNC) begin
            mem_req  <= 1'b0;
        end else if (accept) begin
            mem_req  <= 1'b1;
            mem_addr <= bus.iIF_ADDR;
        end else if (issue) begin
            mem_req  <= 1'b0;
        end
    end

    // Return path: one-cycle registered forward of solicited memory data.
    always_ff @(posedge iGCI_CLOCK or negedge inRESET) begin
        if (!inRESET) begin
            if_valid <= 1'b0;
            if_data  <= '0;
        end else if (iRESET_SYNC) begin
            if_valid <= 1'b0;
        end else begin
            if_valid <= fwd;
            if (fwd) if_data <= bus.iMEM_DATA;
        end
    end

    // Sticky error on a memory return nobody asked for.
    always_ff @(posedge iGCI_CLOCK or negedge inRESET) begin
        if (!inRESET)         oERR <= 1'b0;
        else if (iRESET_SYNC) oERR <= 1'b0;
        else if (unsol)       oERR <= 1'b1;
    end
endmodule

// File: tb/tb_gci_std_display_vram_responder.sv
// Bench for gci_std_display_vram_responder: grant table, scoreboarded
// burst/credit/stall/drain/flush sequences against a behavioural memory.
module tb_gci_std_display_vram_responder;
    localparam int AW  = 19;
    localparam int LAT = 2;

    logic clk = 1'b0, rst_n = 1'b0, rst_sync = 1'b0, arb_lock = 1'b0;
    logic err;
    int   cyc = 0;
    int   n_chk = 0, n_err = 0;

    gci_std_display_vram_responder_if #(.P_MEM_ADDR_N(AW)) bus();

    gci_std_display_vram_responder #(
        .P_MEM_ADDR_N(AW), .P_MAX_OUTSTANDING(4), .P_OUTSTANDING_N(3)
    ) dut (
        .iGCI_CLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync),
        .iARB_LOCK(arb_lock), .bus(bus), .oERR(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] a; int e; } mreq_t;
    mreq_t       mq[$];
    logic [AW-1:0] exp_aq[$];
    logic [31:0] exp_dq[$];
    int          vld_e[$], iss_e[$];
    bit          mem_hold = 1'b0;
    int          rel_cnt = 0, extra_cnt = 0;

    function automatic logic [31:0] mdata(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {13'd0, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: event not allowed here", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    // Scoreboard monitor: expectations pushed on accept, compared on issue/return.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.iIF_ENA && !bus.oIF_BUSY && !bus.iIF_FINISH && !rst_sync) begin
                exp_aq.push_back(bus.iIF_ADDR);
                exp_dq.push_back(mdata(bus.iIF_ADDR));
            end
            if (bus.oMEM_REQ && !bus.iMEM_BUSY) begin
                mq.push_back('{a: bus.oMEM_ADDR, e: cyc + 1});
                iss_e.push_back(cyc + 1);
                if (exp_aq.size() == 0) fail("mem_issue_unexpected");
                else chk("mem_addr", 32'(bus.oMEM_ADDR), 32'(exp_aq.pop_front()));
            end
            if (bus.oIF_VALID) begin
                vld_e.push_back(cyc);
                if (exp_dq.size() == 0) fail("if_valid_unexpected");
                else chk("if_data", bus.oIF_DATA, exp_dq.pop_front());
            end
        end
    end

    // Behavioural memory: in-order, fixed latency; can withhold data or inject a stray return.
    always @(posedge clk) begin
        #2;
        bus.iMEM_VALID = 1'b0;
        if (extra_cnt > 0 && mq.size() == 0) begin
            bus.iMEM_VALID = 1'b1;
            bus.iMEM_DATA  = 32'hBAD0_0000;
            extra_cnt--;
        end else if (mq.size() > 0 && mq[0].e + LAT <= cyc + 1 && (!mem_hold || rel_cnt > 0)) begin
            bus.iMEM_VALID = 1'b1;
            bus.iMEM_DATA  = mdata(mq[0].a);
            void'(mq.pop_front());
            if (mem_hold) rel_cnt--;
        end
    end

    task automatic grant();
        step(); bus.iIF_REQ = 1'b1; nedge();
        step(); bus.iIF_REQ = 1'b0; nedge();
        chk1("grant_ack", bus.oIF_ACK, 1'b1);
    endtask

    task automatic finish_session();
        step(); bus.iIF_FINISH = 1'b1;
        step(); bus.iIF_FINISH = 1'b0;
    endtask

    task automatic wait_empty(input string nm, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_dq.size() == 0 && mq.size() == 0) begin done = 1'b1; break; end
        end
        if (!done) fail(nm);
        step();
    endtask

    typedef struct { logic req, lock, fin, ack, busy; } gvec_t;
    gvec_t gv[19];

    initial begin
        int a0;
        bus.iIF_REQ = 1'b0; bus.iIF_FINISH = 1'b0; bus.iIF_ENA = 1'b0; bus.iIF_ADDR = '0;
        bus.iMEM_BUSY = 1'b0; bus.iMEM_VALID = 1'b0; bus.iMEM_DATA = '0;

        // Reset values
        #2;
        chk1("rst_ack", bus.oIF_ACK, 1'b0);
        chk1("rst_busy", bus.oIF_BUSY, 1'b1);
        chk1("rst_valid", bus.oIF_VALID, 1'b0);
        chk("rst_data", bus.oIF_DATA, 32'h0);
        chk1("rst_memreq", bus.oMEM_REQ, 1'b0);
        chk("rst_memaddr", 32'(bus.oMEM_ADDR), 32'h0);
        chk1("rst_err", err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Grant/lock table: {req, lock, finish} -> {ack, busy}
        gv[0] = '{1, 0, 0, 0, 1};
        gv[1] = '{1, 0, 0, 1, 1};
        gv[2] = '{0, 0, 0, 0, 0};
        gv[3] = '{0, 0, 1, 0, 0};
        for (int i = 4; i < 14; i++) gv[i] = '{1, 1, 0, 0, 1};
        gv[14] = '{1, 0, 0, 0, 1};
        gv[15] = '{0, 1, 0, 1, 1};
        gv[16] = '{0, 1, 0, 0, 0};
        gv[17] = '{0, 0, 1, 0, 0};
        gv[18] = '{0, 0, 0, 0, 1};
        for (int i = 0; i < 19; i++) begin
            step();
            bus.iIF_REQ = gv[i].req; arb_lock = gv[i].lock; bus.iIF_FINISH = gv[i].fin;
            nedge();
            chk1($sformatf("grant_ack[%0d]", i), bus.oIF_ACK, gv[i].ack);
            chk1($sformatf("grant_busy[%0d]", i), bus.oIF_BUSY, gv[i].busy);
        end
        step(); bus.iIF_REQ = 1'b0; arb_lock = 1'b0; bus.iIF_FINISH = 1'b0;

        // Burst of 4, memory latency 2
        grant();
        step(); a0 = cyc + 1; vld_e.delete(); iss_e.delete();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            bus.iIF_ENA = 1'b1; bus.iIF_ADDR = AW'(32'h10 + i);
            nedge(); chk1("burst_busy", bus.oIF_BUSY, 1'b0);
        end
        step(); bus.iIF_ENA = 1'b0;
        wait_empty("burst_timeout", 40);
        chk("burst_iss_cnt", 32'(iss_e.size()), 32'd4);
        chk("burst_vld_cnt", 32'(vld_e.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < iss_e.size()) chk("burst_iss_edge", 32'(iss_e[i]), 32'(a0 + 1 + i));
            if (i < vld_e.size()) chk("burst_vld_edge", 32'(vld_e[i]), 32'(a0 + 3 + i));
        end
        chk("data_hold", bus.oIF_DATA, mdata(AW'(32'h13)));
        finish_session();

        // Credit limit with memory withholding data
        mem_hold = 1'b1; rel_cnt = 0;
        grant();
        for (int i = 0; i < 5; i++) begin
            step(); bus.iIF_ENA = 1'b1; bus.iIF_ADDR = AW'(32'h20 + i);
            nedge(); chk1("credit_busy", bus.oIF_BUSY, i == 4);
        end
        step(); nedge(); chk1("credit_hold_busy", bus.oIF_BUSY, 1'b1);
        step(); rel_cnt = 1; nedge(); chk1("credit_ret_busy", bus.oIF_BUSY, 1'b1);
        step(); nedge(); chk1("credit_free_busy", bus.oIF_BUSY, 1'b0);
        step(); bus.iIF_ENA = 1'b0; mem_hold = 1'b0;
        wait_empty("credit_timeout", 40);
        finish_session();

        // Memory stall on address 0x7FFFF
        grant();
        step(); bus.iIF_ENA = 1'b1; bus.iIF_ADDR = 19'h7FFFF; bus.iMEM_BUSY = 1'b1;
        nedge(); chk1("stall_first_busy", bus.oIF_BUSY, 1'b0);
        iss_e.delete();
        for (int k = 0; k < 3; k++) begin
            step(); bus.iIF_ENA = 1'b1; bus.iIF_ADDR = 19'h00055;
            nedge();
            chk1("stall_busy", bus.oIF_BUSY, 1'b1);
            chk1("stall_memreq", bus.oMEM_REQ, 1'b1);
            chk("stall_memaddr", 32'(bus.oMEM_ADDR), 32'h7FFFF);
        end
        step(); bus.iIF_ENA = 1'b0; bus.iMEM_BUSY = 1'b0;
        nedge();
        chk1("stall_rel_busy", bus.oIF_BUSY, 1'b0);
        chk("stall_rel_addr", 32'(bus.oMEM_ADDR), 32'h7FFFF);
        step(); nedge(); chk1("stall_req_clr", bus.oMEM_REQ, 1'b0);
        wait_empty("stall_timeout", 40);
        chk("stall_iss_cnt", 32'(iss_e.size()), 32'd1);
        finish_session();

        // Finish with two reads in flight; same-cycle ENA dropped
        mem_hold = 1'b1; rel_cnt = 0;
        grant();
        step(); bus.iIF_ENA = 1'b1; bus.iIF_ADDR = 19'h30; nedge();
        step(); bus.iIF_ADDR = 19'h31; nedge();
        step(); bus.iIF_ADDR = 19'h32; bus.iIF_FINISH = 1'b1; nedge();
        step(); bus.iIF_ENA = 1'b0; bus.iIF_FINISH = 1'b0; nedge();
        chk1("drain_busy0", bus.oIF_BUSY, 1'b1);
        chk1("drain_ack", bus.oIF_ACK, 1'b0);
        step(); rel_cnt = 1; nedge(); chk1("drain_busy1", bus.oIF_BUSY, 1'b1);
        step(); nedge(); chk1("drain_busy2", bus.oIF_BUSY, 1'b1);
        step(); rel_cnt = 1; nedge(); chk1("drain_busy3", bus.oIF_BUSY, 1'b1);
        step(); bus.iIF_REQ = 1'b1; nedge(); chk1("drain_idle_ack", bus.oIF_ACK, 1'b0);
        step(); bus.iIF_REQ = 1'b0; nedge(); chk1("drain_regrant", bus.oIF_ACK, 1'b1);
        chk("drain_left", 32'(exp_dq.size()), 32'd0);
        finish_session();

        // Flush with three issued reads in flight
        grant();
        step(); bus.iIF_ENA = 1'b1; bus.iIF_ADDR = 19'h40;
        step(); bus.iIF_ADDR = 19'h41;
        step(); bus.iIF_ADDR = 19'h42;
        step(); bus.iIF_ENA = 1'b0;
        step();
        step(); rst_sync = 1'b1; bus.iIF_REQ = 1'b1;
        exp_aq.delete(); exp_dq.delete();
        step(); rst_sync = 1'b0; nedge();
        chk1("flush_busy", bus.oIF_BUSY, 1'b1);
        chk1("flush_err", err, 1'b0);
        chk1("flush_ack", bus.oIF_ACK, 1'b0);
        for (int r = 0; r < 3; r++) begin
            step(); rel_cnt = 1; nedge();
            chk1("flush_ret_ack", bus.oIF_ACK, 1'b0);
            chk1("flush_ret_err", err, 1'b0);
        end
        step(); nedge(); chk1("flush_post_ack", bus.oIF_ACK, 1'b0);
        step(); bus.iIF_REQ = 1'b0; nedge(); chk1("flush_regrant", bus.oIF_ACK, 1'b1);
        mem_hold = 1'b0;
        finish_session();
        chk1("flush_err_idle", err, 1'b0);

        // Stray return sets sticky error; flush and async reset clear it
        step(); extra_cnt = 1; nedge(); chk1("stray_err0", err, 1'b0);
        step(); nedge(); chk1("stray_err1", err, 1'b1);
        step(); nedge(); chk1("stray_sticky", err, 1'b1);
        step(); rst_sync = 1'b1;
        step(); rst_sync = 1'b0; nedge(); chk1("sync_clr_err", err, 1'b0);
        step(); extra_cnt = 1;
        step(); nedge(); chk1("stray2_err", err, 1'b1);
        step(); rst_n = 1'b0;
        #1;
        chk1("arst_err", err, 1'b0);
        chk1("arst_busy", bus.oIF_BUSY, 1'b1);
        chk1("arst_valid", bus.oIF_VALID, 1'b0);
        step(); rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gci_std_display_vram_responder.md
Name: gci_std_display_vram_responder

Overview:
- Memory-side responder for the display VRAM read interface (REQ/ACK/FINISH/ENA/BUSY/ADDR handshake).
- Grants one read session at a time and forwards each accepted read address to the VRAM memory port.
- Tracks outstanding reads and returns memory data to the requester as IF_VALID/IF_DATA.
- Sits between the display VRAM read interface and the SRAM/SDRAM controller, on the iGCI_CLOCK domain.

Parameters:
P_MEM_ADDR_N, 19, memory word address width
P_MAX_OUTSTANDING, 4, maximum accepted-but-unreturned reads (1..2^P_OUTSTANDING_N-1)
P_OUTSTANDING_N, 3, width of outstanding/discard counters

Ports:
iGCI_CLOCK  in  1  system clock; all logic rising-edge
inRESET  in  1  reset, asynchronous, active-low
iRESET_SYNC  in  1  synchronous flush, same effect as reset except discard tracking
iARB_LOCK  in  1  memory owned by another master; blocks new grants
iIF_REQ  in  1  session request (level)
oIF_ACK  out  1  one-cycle grant pulse
iIF_FINISH  in  1  session end pulse
iIF_ENA  in  1  read command valid
oIF_BUSY  out  1  read command not accepted this cycle
iIF_ADDR  in  P_MEM_ADDR_N  read address, sampled with iIF_ENA
oIF_VALID  out  1  read data valid (one-cycle pulse per word)
oIF_DATA  out  32  read data
oMEM_REQ  out  1  memory read request (held while iMEM_BUSY)
oMEM_ADDR  out  P_MEM_ADDR_N  memory read address
iMEM_BUSY  in  1  memory cannot take the request this cycle
iMEM_VALID  in  1  memory read data valid; in-order, any latency
iMEM_DATA  in  32  memory read data
oERR  out  1  sticky: unsolicited memory return detected

Behaviour:
- Reset (inRESET low): state IDLE; all counters 0. Output reset values: oIF_ACK=0, oIF_BUSY=1, oIF_VALID=0, oIF_DATA=0, oMEM_REQ=0, oMEM_ADDR=0, oERR=0.
- States: IDLE, ACK, SESSION, DRAIN.
  - IDLE -> ACK when iIF_REQ && !iARB_LOCK && discard==0.
  - ACK -> SESSION unconditionally. oIF_ACK=1 only in ACK.
  - SESSION -> on iIF_FINISH: DRAIN if outstanding!=0, else IDLE.
  - DRAIN -> IDLE on the cycle outstanding becomes 0, including the count==1 && iMEM_VALID case.
- Accept condition: state==SESSION && iIF_ENA && !oIF_BUSY && !iIF_FINISH. FINISH wins over a same-cycle ENA; that ENA is dropped.
- oIF_BUSY (combinational) = state!=SESSION || outstanding>=P_MAX_OUTSTANDING || (oMEM_REQ && iMEM_BUSY).
- Memory stage:
  - An accept registers oMEM_REQ=1 and oMEM_ADDR=iIF_ADDR on the next edge.
  - A request issues on any cycle with oMEM_REQ && !iMEM_BUSY. oMEM_REQ clears after issue unless a new accept occurs in the same cycle.
  - oMEM_ADDR holds stable while stalled.
- Outstanding counter: +1 on accept, -1 on a forwarded iMEM_VALID; both in one cycle leaves it unchanged. Never exceeds P_MAX_OUTSTANDING.
- Return path:
  - iMEM_VALID with discard==0 and outstanding!=0 produces oIF_VALID=1 and oIF_DATA=iMEM_DATA on the next edge. Latency is 1 cycle.
  - oIF_DATA holds its last value when oIF_VALID=0.
  - Minimum ENA-to-VALID time = 2 + memory latency.
- Unsolicited return (iMEM_VALID with discard==0 and outstanding==0): dropped and oERR set. oERR clears only on reset or iRESET_SYNC.
- iRESET_SYNC:
  - Forces state IDLE, oMEM_REQ=0, oIF_VALID=0, outstanding=0, oERR=0.
  - Loads discard = outstanding minus (1 if that request had not issued yet, i.e. oMEM_REQ && iMEM_BUSY).
  - Later iMEM_VALID pulses decrement discard, are not forwarded, and do not set oERR.
  - No new grant until discard==0.
- iARB_LOCK affects only the IDLE->ACK transition; an active session continues.
- iIF_REQ deasserted during ACK: still go to SESSION. The session ends only on FINISH.

Test Plan:
- Grant: iIF_REQ=1, iARB_LOCK=0 in IDLE -> oIF_ACK high exactly 1 cycle (the cycle after REQ), oIF_BUSY low the following cycle; with iARB_LOCK=1, no ACK for 10 cycles, ACK 1 cycle after lock release.
- Burst, memory latency 2, no busy: 4 back-to-back ENA at addr 0x00010..0x00013 -> oMEM_ADDR sequence 0x10..0x13 on consecutive cycles; oIF_VALID 4 consecutive cycles starting 4 cycles after first ENA; data in order.
- Credit limit: P_MAX_OUTSTANDING=4, memory withholds data -> 5th ENA sees oIF_BUSY=1; after one iMEM_VALID, BUSY drops the same cycle the count falls to 3.
- Memory stall: iMEM_BUSY=1 for 3 cycles with oMEM_REQ=1, addr 0x7FFFF -> oIF_BUSY=1 and oMEM_ADDR stable at 0x7FFFF those cycles; single issue when iMEM_BUSY drops.
- Finish with 2 in flight -> state DRAIN, oIF_BUSY=1; both words forwarded, IDLE the cycle after the last return; new REQ then ACKed.
- iRESET_SYNC with 3 issued reads in flight -> next 3 iMEM_VALID not forwarded, oERR=0, REQ not ACKed until the 3rd return; an extra iMEM_VALID afterwards in IDLE sets oERR=1.
